icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache. It is the responder to the fetch stage's 8-byte-aligned instruction request.
- A hit returns the 64-bit double-word (two instructions) combinationally in the same cycle.
- A miss issues one load to the tagged main-memory bus. The returned line is filled, and the access then hits.
- Sits between fetch and the shared memory port. Only one miss is outstanding at a time.

---
 rtl/icache_direct_pkg.sv | 24 ++
 rtl/icache_direct_if.sv | 38 +++
 rtl/icache_direct_mem.sv | 45 ++++
 rtl/icache_direct.sv | 100 ++++++++++
 tb/tb_icache_direct.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/icache_direct_pkg.sv
// rtl/icache_direct_pkg.sv - shared types and widths for the instruction cache
// Purpose: bus command encoding, memory tag width and the cache line record.
// Ports: none (package).
package icache_direct_pkg;

    localparam int XLEN         = 32;
    localparam int MEM_TAG_W    = 4;
    // Tag field is sized for the smallest legal index so any NUM_LINES fits;
    // unused upper bits are stored as zero.
    localparam int ICACHE_TAG_W = XLEN - 3;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [63:0]             data;
    } ICACHE_LINE;

endpackage

// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - fetch and memory-port signals of the instruction cache
// Purpose: bundles the fetch request/response and tagged memory bus signals.
// Ports: slave = cache side, master = fetch stage plus memory side.
interface icache_direct_if;
    import icache_direct_pkg::*;

    logic [XLEN-1:0]      proc2Icache_addr_in;
    logic [63:0]          Icache2proc_data_out;
    logic                 Icache2proc_valid_out;
    BUS_COMMAND           proc2mem_command_out;
    logic [XLEN-1:0]      proc2mem_addr_out;
    logic [MEM_TAG_W-1:0] mem2proc_response_in;
    logic [63:0]          mem2proc_data_in;
    logic [MEM_TAG_W-1:0] mem2proc_tag_in;

    modport slave (
        input  proc2Icache_addr_in,
        output Icache2proc_data_out,
        output Icache2proc_valid_out,
        output proc2mem_command_out,
        output proc2mem_addr_out,
        input  mem2proc_response_in,
        input  mem2proc_data_in,
        input  mem2proc_tag_in
    );

    modport master (
        output proc2Icache_addr_in,
        input  Icache2proc_data_out,
        input  Icache2proc_valid_out,
        input  proc2mem_command_out,
        input  proc2mem_addr_out,
        output mem2proc_response_in,
        output mem2proc_data_in,
        output mem2proc_tag_in
    );

endinterface

// File: rtl/icache_direct_mem.sv
// rtl/icache_direct_mem.sv - line array of the direct-mapped instruction cache
// Purpose: valid/tag/data storage, one combinational read port, one synchronous write port.
// Ports: clock, reset (sync, active-high, clears valid bits only),
//        rd_idx/rd_line (read), wr_en/wr_idx/wr_tag/wr_data (fill write).
module icache_mem
    import icache_direct_pkg::*;
#(
    parameter int NUM_LINES = 32,
    localparam int IDX_W    = $clog2(NUM_LINES)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [IDX_W-1:0]        rd_idx,
    output ICACHE_LINE              rd_line,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [ICACHE_TAG_W-1:0] wr_tag,
    input  logic [63:0]             wr_data
);

    logic [NUM_LINES-1:0]    valid_q;
    logic [ICACHE_TAG_W-1:0] tag_q  [NUM_LINES];
    logic [63:0]             data_q [NUM_LINES];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_line.valid = valid_q[rd_idx];
    assign rd_line.tag   = tag_q[rd_idx];
    assign rd_line.data  = data_q[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache
// Purpose: same-cycle hit path for 8-byte fetches, single outstanding miss to tagged memory.
// Ports: clock, reset (sync, active-high), bus (icache_direct_if.slave: fetch address in,
//        line/valid out, memory command/address out, memory response/data/tag in).
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int NUM_LINES = 32
) (
    input  logic            clock,
    input  logic            reset,
    icache_direct_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = XLEN - 3 - IDX_W;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t               state;
    logic [XLEN-1:0]      pending_addr;
    logic [MEM_TAG_W-1:0] pending_mem_tag;
    BUS_COMMAND           cmd_q;

    logic [IDX_W-1:0]        cur_idx;
    logic [ICACHE_TAG_W-1:0] cur_tag;
    logic [IDX_W-1:0]        pend_idx;
    logic [ICACHE_TAG_W-1:0] pend_tag;
    ICACHE_LINE              rd_line;
    logic                    hit;
    logic                    fill;
    logic                    unused_offset;

    assign cur_idx  = bus.proc2Icache_addr_in[3+IDX_W-1:3];
    assign cur_tag  = {{IDX_W{1'b0}}, bus.proc2Icache_addr_in[XLEN-1:3+IDX_W]};
    assign pend_idx = pending_addr[3+IDX_W-1:3];
    assign pend_tag = {{IDX_W{1'b0}}, pending_addr[XLEN-1:3+IDX_W]};
    assign unused_offset = ^bus.proc2Icache_addr_in[2:0];

    assign hit = rd_line.valid && (rd_line.tag == cur_tag);

    // Tag 0 means "no transaction", so a cleared pending tag never matches.
    assign fill = (state == WAIT) && !reset && (pending_mem_tag != '0)
               && (bus.mem2proc_tag_in == pending_mem_tag);

    icache_mem #(.NUM_LINES(NUM_LINES)) u_mem (
        .clock   (clock),
        .reset   (reset),
        .rd_idx  (cur_idx),
        .rd_line (rd_line),
        .wr_en   (fill),
        .wr_idx  (pend_idx),
        .wr_tag  (pend_tag),
        .wr_data (bus.mem2proc_data_in)
    );

    // Gated by reset so the fetch stage and memory see a quiet cache while
    // the synchronous clear has not yet taken effect.
    assign bus.Icache2proc_valid_out = hit && !reset;
    assign bus.Icache2proc_data_out  = rd_line.data;
    assign bus.proc2mem_command_out  = reset ? BUS_NONE : cmd_q;
    assign bus.proc2mem_addr_out     = pending_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            pending_addr    <= '0;
            pending_mem_tag <= '0;
            cmd_q           <= BUS_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        pending_addr <= {bus.proc2Icache_addr_in[XLEN-1:3], 3'b000};
                        cmd_q        <= BUS_LOAD;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    // Load is re-issued each cycle until memory hands back a tag.
                    if (bus.mem2proc_response_in != '0) begin
                        pending_mem_tag <= bus.mem2proc_response_in;
                        cmd_q           <= BUS_NONE;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (fill) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cmd_q <= BUS_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard testbench for icache_direct
module tb_icache_direct;
    import icache_direct_pkg::*;

    logic clock;
    logic reset;

    icache_direct_if bus ();

    icache_direct #(.NUM_LINES(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic        e_valid;
        logic [63:0] e_data;
        logic        e_load;
        logic [31:0] e_maddr;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc_no;

    localparam logic [63:0] D1 = 64'h00A00093_00500113;
    localparam logic [63:0] D2 = 64'h11112222_33334444;
    localparam logic [63:0] D3 = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] DX = 64'h77777777_77777777;

    // One cycle of stimulus; the expected outputs for that cycle go into the queue.
    task automatic cyc(input logic r, input logic [31:0] a, input logic [3:0] resp,
                       input logic [3:0] tg, input logic [63:0] d,
                       input logic ev, input logic [63:0] ed,
                       input logic el, input logic [31:0] ea);
        exp_t e;
        @(posedge clock);
        #1;
        reset                    = r;
        bus.proc2Icache_addr_in  = a;
        bus.mem2proc_response_in = resp;
        bus.mem2proc_tag_in      = tg;
        bus.mem2proc_data_in     = d;
        cyc_no++;
        e.id = cyc_no; e.e_valid = ev; e.e_data = ed; e.e_load = el; e.e_maddr = ea;
        exp_q.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents in each cycle with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.Icache2proc_valid_out !== e.e_valid) begin
                    errors++;
                    $display("FAIL valid c%0d: got %0b expected %0b", e.id,
                             bus.Icache2proc_valid_out, e.e_valid);
                end
                if (e.e_valid) begin
                    checks++;
                    if (bus.Icache2proc_data_out !== e.e_data) begin
                        errors++;
                        $display("FAIL data c%0d: got %h expected %h", e.id,
                                 bus.Icache2proc_data_out, e.e_data);
                    end
                end
                checks++;
                if (bus.proc2mem_command_out !== (e.e_load ? BUS_LOAD : BUS_NONE)) begin
                    errors++;
                    $display("FAIL command c%0d: got %0d expected %0d", e.id,
                             bus.proc2mem_command_out, e.e_load ? 1 : 0);
                end
                if (e.e_load) begin
                    checks++;
                    if (bus.proc2mem_addr_out !== e.e_maddr) begin
                        errors++;
                        $display("FAIL mem_addr c%0d: got %h expected %h", e.id,
                                 bus.proc2mem_addr_out, e.e_maddr);
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc_no = 0;
        reset                    = 1'b1;
        bus.proc2Icache_addr_in  = 32'h100;
        bus.mem2proc_response_in = '0;
        bus.mem2proc_tag_in      = '0;
        bus.mem2proc_data_in     = '0;

        // reset state
        cyc(1, 32'h100, 0, 0, 0,  0, 0,  0, 0);
        cyc(1, 32'h100, 0, 0, 0,  0, 0,  0, 0);
        // cold miss on 0x100, accepted with tag 3, returned five cycles later
        cyc(0, 32'h100, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h100, 3, 0, 0,  0, 0,  1, 32'h100);
        cyc(0, 32'h100, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h100, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h100, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h100, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h100, 0, 3, D1, 0, 0,  0, 0);
        cyc(0, 32'h100, 0, 0, 0,  1, D1, 0, 0);
        // hit on the second word of the same line
        cyc(0, 32'h104, 0, 0, 0,  1, D1, 0, 0);
        cyc(0, 32'h104, 0, 0, 0,  1, D1, 0, 0);
        // conflict miss on 0x200 with three refusals, then tag 5
        cyc(0, 32'h200, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h200, 0, 0, 0,  0, 0,  1, 32'h200);
        cyc(0, 32'h200, 0, 0, 0,  0, 0,  1, 32'h200);
        cyc(0, 32'h200, 0, 0, 0,  0, 0,  1, 32'h200);
        cyc(0, 32'h200, 5, 0, 0,  0, 0,  1, 32'h200);
        cyc(0, 32'h200, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h200, 0, 5, D2, 0, 0,  0, 0);
        cyc(0, 32'h200, 0, 0, 0,  1, D2, 0, 0);
        // 0x100 was evicted; miss, then redirect to resident 0x200 during WAIT
        cyc(0, 32'h100, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h100, 2, 0, 0,  0, 0,  1, 32'h100);
        cyc(0, 32'h200, 0, 0, 0,  1, D2, 0, 0);
        cyc(0, 32'h200, 0, 7, DX, 1, D2, 0, 0);
        cyc(0, 32'h200, 0, 2, D1, 1, D2, 0, 0);
        cyc(0, 32'h100, 0, 0, 0,  1, D1, 0, 0);
        // miss on 0x108 (index 1), reset while waiting, then the old tag returns
        cyc(0, 32'h108, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h108, 4, 0, 0,  0, 0,  1, 32'h108);
        cyc(0, 32'h108, 0, 0, 0,  0, 0,  0, 0);
        cyc(1, 32'h100, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h100, 0, 4, D3, 0, 0,  0, 0);
        cyc(0, 32'h100, 0, 0, 0,  0, 0,  1, 32'h100);
        cyc(0, 32'h108, 0, 0, 0,  0, 0,  1, 32'h100);
        // reset while a load is being requested
        cyc(1, 32'h108, 0, 0, 0,  0, 0,  0, 0);
        cyc(0, 32'h108, 0, 0, 0,  0, 0,  0, 0);

        @(negedge clock);
        @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
